decoder_38_strobe: RTL and testbench

- Registered 3-to-8 one-hot decoder; the inverse of the team's 8-to-3 encoder.
- Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles, then an optional idle gap.
- Sits between the control logic and eight select/strobe targets (chip selects, mux enables), so the encoder/decoder pair round-trips a line index.

---
 rtl/dec38_pkg.sv | 17 +
 rtl/dec38_onehot.sv | 11 +
 rtl/decoder_38_strobe.sv | 131 +++++++++++++
 tb/tb_decoder_38_strobe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec38_pkg.sv
// Shared types and widths for the 3-to-8 strobe decoder.
package dec38_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2
  } dec38_state_e;

  function automatic int unsigned dec38_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dec38_onehot.sv
// Pure combinational 3-to-8 one-hot decode.
module dec38_onehot
  import dec38_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [OUT_W-1:0]  o_onehot
);

  assign o_onehot = OUT_W'(1) << i_code;

endmodule

// File: rtl/decoder_38_strobe.sv
// Registered 3-to-8 one-hot strobe decoder with hold and idle-gap timing.
// Optional even-parity check on the code is enabled with `define DEC38_PARITY_EN.
module decoder_38_strobe
  import dec38_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code,
`ifdef DEC38_PARITY_EN
  input  logic              code_par,
  output logic              par_err,
`endif
  output logic [OUT_W-1:0]  y,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntMax = dec38_max(HOLD_CYCLES, GAP_CYCLES) - 1;
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLoad  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  if (HOLD_CYCLES < 1 || CNT_W < 1 || CNT_W > 32 ||
      (CNT_W < 32 && CntMax >= (32'd1 << CNT_W))) begin : g_bad_params
    $error("decoder_38_strobe: HOLD_CYCLES must be >= 1 and fit the CNT_W counter");
  end

  dec38_state_e     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_y;
  logic             r_busy;
  logic             r_done;
  logic [OUT_W-1:0] w_onehot;
  logic             w_par_ok;

  dec38_onehot u_onehot (
    .i_code   (code),
    .o_onehot (w_onehot)
  );

`ifdef DEC38_PARITY_EN
  logic r_par_err;
  assign w_par_ok = ~^{code, code_par};
  assign par_err  = r_par_err;
`else
  assign w_par_ok = 1'b1;
`endif

  assign in_ready = en && (r_state == StIdle);
  assign y        = r_y;
  assign busy     = r_busy;
  assign done     = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_y       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef DEC38_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
`ifdef DEC38_PARITY_EN
      r_par_err <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          if (in_valid && in_ready) begin
            if (w_par_ok) begin
              r_y     <= w_onehot;
              r_state <= StDrive;
              r_cnt   <= HoldLoad;
              r_busy  <= 1'b1;
            end
`ifdef DEC38_PARITY_EN
            else begin
              r_par_err <= 1'b1;
            end
`endif
          end
        end
        StDrive: begin
          // Abort takes priority over normal completion, so no done pulse.
          if (!en) begin
            r_y     <= '0;
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_y    <= '0;
            r_done <= 1'b1;
            if (GAP_CYCLES > 0) begin
              r_state <= StGap;
              r_cnt   <= GapLoad;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StGap: begin
          if (!en || r_cnt == '0) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_y     <= '0;
          r_state <= StIdle;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_38_strobe.sv
// Bench for decoder_38_strobe: two instances (GAP_CYCLES=1 and 0) against a timeline model.
module tb_decoder_38_strobe;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [2:0] code;
`ifdef DEC38_PARITY_EN
  logic       code_par;
  logic       par_err_g [2];
`endif
  logic       in_ready_g [2];
  logic       busy_g [2];
  logic       done_g [2];
  logic [7:0] y_g [2];

  always #5 clk = ~clk;

  decoder_38_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) u_dut_g1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready_g[0]),
    .code     (code),
`ifdef DEC38_PARITY_EN
    .code_par (code_par),
    .par_err  (par_err_g[0]),
`endif
    .y        (y_g[0]),
    .busy     (busy_g[0]),
    .done     (done_g[0])
  );

  decoder_38_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) u_dut_g0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready_g[1]),
    .code     (code),
`ifdef DEC38_PARITY_EN
    .code_par (code_par),
    .par_err  (par_err_g[1]),
`endif
    .y        (y_g[1]),
    .busy     (busy_g[1]),
    .done     (done_g[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit in_rst;

  // Timeline model: per instance, the cycle window in which the strobe is high,
  // the last busy cycle, and the cycles at which done / par_err are expected.
  int         hi_start [2];
  int         hi_end   [2];
  int         busy_end [2];
  int         done_cyc [2];
  int         perr_cyc [2];
  logic [2:0] line     [2];
  bit         acc_flag [2];

  function automatic int gap_of(input int g);
    return (g == 0) ? 1 : 0;
  endfunction

  function automatic bit par_ok();
`ifdef DEC38_PARITY_EN
    return ~^{code, code_par};
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_code(input logic [2:0] c);
    code = c;
`ifdef DEC38_PARITY_EN
    code_par = ^c;
`endif
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      hi_start[g] = 0;
      hi_end[g]   = -1;
      busy_end[g] = -1;
      done_cyc[g] = -1;
      perr_cyc[g] = -1;
      line[g]     = 3'd0;
      acc_flag[g] = 1'b0;
    end
  endtask

  task automatic model_edge();
    cyc++;
    for (int g = 0; g < 2; g++) begin
      bit busy_prev;
      acc_flag[g] = 1'b0;
      if (in_rst) continue;
      busy_prev = (cyc - 1 <= busy_end[g]);
      if (busy_prev && !en) begin
        if (hi_end[g] >= cyc) hi_end[g] = cyc - 1;
        busy_end[g] = cyc - 1;
        if (done_cyc[g] >= cyc) done_cyc[g] = -1;
      end else if (!busy_prev && en && in_valid) begin
        acc_flag[g] = 1'b1;
        if (par_ok()) begin
          line[g]     = code;
          hi_start[g] = cyc;
          hi_end[g]   = cyc + H - 1;
          busy_end[g] = cyc + H - 1 + gap_of(g);
          done_cyc[g] = cyc + H;
        end else begin
          perr_cyc[g] = cyc;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int g = 0; g < 2; g++) begin
      logic [7:0] exp_y;
      exp_y = (cyc >= hi_start[g] && cyc <= hi_end[g]) ? (8'd1 << line[g]) : 8'd0;
      check_val($sformatf("y%0d", g), y_g[g], exp_y);
      check_val($sformatf("onehot%0d", g), {7'd0, $onehot0(y_g[g])}, 8'd1);
      check_val($sformatf("busy%0d", g), {7'd0, busy_g[g]}, {7'd0, cyc <= busy_end[g]});
      check_val($sformatf("done%0d", g), {7'd0, done_g[g]}, {7'd0, cyc == done_cyc[g]});
      check_val($sformatf("in_ready%0d", g), {7'd0, in_ready_g[g]},
                {7'd0, en && !(cyc <= busy_end[g])});
`ifdef DEC38_PARITY_EN
      check_val($sformatf("par_err%0d", g), {7'd0, par_err_g[g]}, {7'd0, cyc == perr_cyc[g]});
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    set_code(3'd0);
    in_rst   = 1'b1;
    model_reset();
    #1;
    check_outputs();
    repeat (2) step();
    rst_n  = 1'b1;
    in_rst = 1'b0;

    // Single strobe on line 5.
    en       = 1'b1;
    in_valid = 1'b1;
    set_code(3'd5);
    step();
    in_valid = 1'b0;
    repeat (8) step();

    // Back-to-back sweep of all lines, advancing whenever the GAP=0 instance accepts.
    begin
      int k;
      k        = 0;
      in_valid = 1'b1;
      set_code(3'd0);
      for (int i = 0; i < 60 && k < 8; i++) begin
        step();
        if (acc_flag[1]) begin
          k++;
          set_code(3'(k));
        end
      end
      in_valid = 1'b0;
      repeat (6) step();
    end

    // Abort after two drive cycles, then an immediate re-accept.
    in_valid = 1'b1;
    set_code(3'd2);
    step();
    in_valid = 1'b0;
    repeat (2) step();
    en = 1'b0;
    step();
    en       = 1'b1;
    in_valid = 1'b1;
    set_code(3'd6);
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // Asynchronous reset in the middle of a strobe.
    in_valid = 1'b1;
    set_code(3'd7);
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    in_rst = 1'b1;
    model_reset();
    check_outputs();
    step();
    rst_n    = 1'b1;
    in_rst   = 1'b0;
    in_valid = 1'b1;
    set_code(3'd1);
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // Enable low blocks accepts; raising it accepts at once.
    en       = 1'b0;
    in_valid = 1'b1;
    set_code(3'd4);
    repeat (10) step();
    en = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();

`ifdef DEC38_PARITY_EN
    in_valid = 1'b1;
    code     = 3'd3;
    code_par = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    in_valid = 1'b1;
    code_par = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (6) step();
`endif

    // Random traffic, including code changes mid-strobe and occasional aborts.
    repeat (400) begin
      en       = ($urandom_range(0, 9) != 0);
      in_valid = 1'($urandom_range(0, 1));
      set_code(3'($urandom));
`ifdef DEC38_PARITY_EN
      if ($urandom_range(0, 3) == 0) code_par = 1'($urandom);
`endif
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
